// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner. It drives one active-low row at a
// time, synchronises the columns, classifies whole scan frames, debounces them
// and presents one key code per accepted press on a valid/ack handshake.
module keypad_scanner #(
  parameter int SCAN_DIV        = 25000,
  parameter int DIV_BITS        = 17,
  parameter int DEBOUNCE_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] row_select,
  input  logic [3:0] col_in,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_held,
  output logic       overrun
);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_e;

  localparam logic [DIV_BITS-1:0] DIV_LAST = DIV_BITS'(SCAN_DIV - 1);
  localparam logic [3:0]          DB_LAST  = 4'(DEBOUNCE_FRAMES);

  logic [DIV_BITS-1:0] div_q, div_d;
  logic [1:0]          row_q, row_d;
  logic [3:0]          row_sel_q, row_sel_d;
  logic [3:0]          sync1_q, sync2_q;
  // Frame accumulator: low-bit count so far (saturates at 2) and its code.
  logic [1:0]          acc_cnt_q, acc_cnt_d;
  logic [3:0]          acc_code_q, acc_code_d;
  state_e              state_q, state_d;
  logic [3:0]          cand_q, cand_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [3:0]          key_code_q, key_code_d;
  logic                key_valid_q, key_valid_d;
  logic                key_held_q, key_held_d;
  logic                overrun_q, overrun_d;

  logic       tick, frame_end, accept;
  logic [3:0] col_low;
  logic [2:0] hits, sum;
  logic [1:0] col_idx, frame_cnt;
  logic [3:0] frame_code, cnt_inc;

  // Row stepping and per-frame accumulation of low column bits.
  always_comb begin
    tick      = (div_q == DIV_LAST);
    frame_end = tick && (row_q == 2'd3);
    col_low   = ~sync2_q;
    hits      = 3'(col_low[0]) + 3'(col_low[1]) + 3'(col_low[2]) + 3'(col_low[3]);
    col_idx   = 2'd0;
    for (int c = 0; c < 4; c++)
      if (col_low[c]) col_idx = 2'(c);
    sum        = {1'b0, acc_cnt_q} + hits;
    frame_cnt  = (sum >= 3'd2) ? 2'd2 : sum[1:0];
    frame_code = (acc_cnt_q == 2'd0 && hits == 3'd1) ? {row_q, col_idx} : acc_code_q;

    div_d      = tick ? '0 : div_q + 1'b1;
    row_d      = row_q;
    row_sel_d  = row_sel_q;
    acc_cnt_d  = acc_cnt_q;
    acc_code_d = acc_code_q;
    if (tick) begin
      row_d     = row_q + 2'd1;
      row_sel_d = {row_sel_q[2:0], row_sel_q[3]};
      if (frame_end) begin
        acc_cnt_d  = 2'd0;
        acc_code_d = 4'd0;
      end else begin
        acc_cnt_d  = frame_cnt;
        acc_code_d = frame_code;
      end
    end
  end

  // Debounce FSM, evaluated on frame end, plus the valid/ack handshake.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    accept      = 1'b0;
    cnt_inc     = cnt_q + 4'd1;
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
    overrun_d   = overrun_q;

    if (frame_end) begin
      case (state_q)
        IDLE: if (frame_cnt == 2'd1) begin
          cand_d = frame_code;
          if (DB_LAST == 4'd1) begin
            state_d = PRESSED;
            cnt_d   = 4'd0;
            accept  = 1'b1;
          end else begin
            state_d = DEBOUNCE;
            cnt_d   = 4'd1;
          end
        end
        DEBOUNCE: if (frame_cnt == 2'd1 && frame_code == cand_q) begin
          if (cnt_inc == DB_LAST) begin
            state_d = PRESSED;
            cnt_d   = 4'd0;
            accept  = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
        // A second key or a chord while pressed is ignored until release.
        PRESSED: if (frame_cnt == 2'd0) begin
          if (DB_LAST == 4'd1) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end else begin
            state_d = RELEASE;
            cnt_d   = 4'd1;
          end
        end
        RELEASE: if (frame_cnt == 2'd0) begin
          if (cnt_inc == DB_LAST) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          state_d = PRESSED;
          cnt_d   = 4'd0;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end

    key_held_d = (state_d == PRESSED) || (state_d == RELEASE);

    // A same-cycle ack consumes the old event; the new event still wins.
    if (accept) begin
      key_code_d  = frame_code;
      key_valid_d = 1'b1;
      if (key_valid_q && !key_ack) overrun_d = 1'b1;
      else if (key_ack)            overrun_d = 1'b0;
    end else if (key_ack && key_valid_q) begin
      key_valid_d = 1'b0;
      overrun_d   = 1'b0;
    end
  end

  // All state registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q       <= '0;
      row_q       <= 2'd0;
      row_sel_q   <= 4'b1110;
      sync1_q     <= 4'b1111;
      sync2_q     <= 4'b1111;
      acc_cnt_q   <= 2'd0;
      acc_code_q  <= 4'd0;
      state_q     <= IDLE;
      cand_q      <= 4'd0;
      cnt_q       <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      div_q       <= div_d;
      row_q       <= row_d;
      row_sel_q   <= row_sel_d;
      sync1_q     <= col_in;
      sync2_q     <= sync1_q;
      acc_cnt_q   <= acc_cnt_d;
      acc_code_q  <= acc_code_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      overrun_q   <= overrun_d;
    end
  end

  assign row_select = row_sel_q;
  assign key_code   = key_code_q;
  assign key_valid  = key_valid_q;
  assign key_held   = key_held_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_FRAMES=3
// (16-cycle frames). A keypad model turns the pressed-key mask into col_in.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_select;
  logic [3:0] col_in;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack = 1'b0;
  logic       key_held;
  logic       overrun;
  logic [15:0] keys = 16'h0;

  int checks = 0;
  int errors = 0;
  int cyc;

  keypad_scanner #(.SCAN_DIV(4), .DIV_BITS(2), .DEBOUNCE_FRAMES(3)) dut (
    .clk(clk), .rst(rst), .row_select(row_select), .col_in(col_in),
    .key_code(key_code), .key_valid(key_valid), .key_ack(key_ack),
    .key_held(key_held), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row_select[r]) col_in[c] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    key_ack = 1'b0;
    step(3);
    rst = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (!key_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic ack_once();
    key_ack = 1'b1;
    step(1);
    key_ack = 1'b0;
  endtask

  initial begin
    // Reset then idle scanning
    keys = 16'h0;
    do_reset();
    chk("rst_row", 32'(row_select), 32'hE);
    chk("rst_valid", 32'(key_valid), 0);
    chk("rst_held", 32'(key_held), 0);
    chk("rst_ovr", 32'(overrun), 0);
    chk("rst_code", 32'(key_code), 0);
    step(4);  chk("row_4", 32'(row_select), 32'hD);
    step(4);  chk("row_8", 32'(row_select), 32'hB);
    step(4);  chk("row_12", 32'(row_select), 32'h7);
    step(4);  chk("row_16", 32'(row_select), 32'hE);
    chk("idle_valid", 32'(key_valid), 0);
    chk("idle_held", 32'(key_held), 0);
    chk("idle_ovr", 32'(overrun), 0);

    // Single press of key 9 (row 2, col 1), accepted after the third frame
    keys = 16'h0;
    do_reset();
    keys = 16'h1 << 9;
    wait_valid(80, cyc);
    chk("press_valid", 32'(key_valid), 1);
    chk("press_latency", 32'(cyc), 48);
    chk("press_code", 32'(key_code), 9);
    chk("press_held", 32'(key_held), 1);
    step(64);
    chk("hold_valid", 32'(key_valid), 1);
    chk("hold_no_ovr", 32'(overrun), 0);
    ack_once();
    chk("ack_valid", 32'(key_valid), 0);
    chk("ack_code", 32'(key_code), 9);
    chk("ack_held", 32'(key_held), 1);
    keys = 16'h0;
    step(80);
    chk("rel_held", 32'(key_held), 0);
    chk("rel_valid", 32'(key_valid), 0);

    // Bounce: key 9 present one frame, absent the next, ten times
    do_reset();
    for (int i = 0; i < 10; i++) begin
      keys = 16'h1 << 9;
      step(16);
      keys = 16'h0;
      step(16);
      chk("bounce_valid", 32'(key_valid), 0);
      chk("bounce_held", 32'(key_held), 0);
    end

    // Chord of keys 0 and 5 yields nothing; key 0 alone then accepted
    do_reset();
    keys = 16'h0021;
    step(64);
    chk("chord_valid", 32'(key_valid), 0);
    chk("chord_held", 32'(key_held), 0);
    keys = 16'h0001;
    wait_valid(80, cyc);
    chk("chord_rel_valid", 32'(key_valid), 1);
    chk("chord_rel_latency", 32'(cyc), 48);
    chk("chord_rel_code", 32'(key_code), 0);

    // Overrun: key 3 left unacked, release, then key 12
    keys = 16'h0;
    do_reset();
    keys = 16'h1 << 3;
    wait_valid(80, cyc);
    chk("ovr_first_valid", 32'(key_valid), 1);
    chk("ovr_first_code", 32'(key_code), 3);
    keys = 16'h0;
    step(64);
    chk("ovr_released", 32'(key_held), 0);
    chk("ovr_pending", 32'(key_valid), 1);
    keys = 16'h1 << 12;
    step(47);
    chk("ovr_not_yet", 32'(overrun), 0);
    chk("ovr_old_code", 32'(key_code), 3);
    step(1);
    chk("ovr_flag", 32'(overrun), 1);
    chk("ovr_valid", 32'(key_valid), 1);
    chk("ovr_code", 32'(key_code), 12);
    ack_once();
    chk("ovr_ack_valid", 32'(key_valid), 0);
    chk("ovr_ack_flag", 32'(overrun), 0);

    // Reset mid-debounce of key 6 discards the partial count
    keys = 16'h0;
    do_reset();
    keys = 16'h1 << 6;
    step(32);
    chk("mid_valid", 32'(key_valid), 0);
    rst = 1'b1;
    step(2);
    chk("mid_rst_row", 32'(row_select), 32'hE);
    chk("mid_rst_valid", 32'(key_valid), 0);
    chk("mid_rst_held", 32'(key_held), 0);
    chk("mid_rst_ovr", 32'(overrun), 0);
    chk("mid_rst_code", 32'(key_code), 0);
    rst = 1'b0;
    step(47);
    chk("mid_early", 32'(key_valid), 0);
    step(1);
    chk("mid_valid_after", 32'(key_valid), 1);
    chk("mid_code", 32'(key_code), 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
